// File: rtl/weight_loader.sv
// weight_loader: collects an NxN row-major weight stream and writes it column-major to weight memory.
module weight_loader #(
  parameter int N = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 13'h000F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN) + 1;
  localparam int IW = $clog2(NN);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] rd;
  logic [DATA_WIDTH-1:0] wbuf [NN];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      for (int i = 0; i < NN; i++) wbuf[i] <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (state == COLLECT && in_valid) wbuf[cnt[IW-1:0]] <= in_data;
    end
  end
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    if (state == IDLE && start) begin
      nxt = COLLECT;
      cnt_nxt = '0;
    end else if (state == COLLECT && in_valid) begin
      nxt = cnt == LAST ? WRITE : COLLECT;
      cnt_nxt = cnt == LAST ? '0 : cnt + 1'b1;
    end else if (state == WRITE) begin
      nxt = cnt == LAST ? DONE : WRITE;
      cnt_nxt = cnt == LAST ? '0 : cnt + 1'b1;
    end else if (state == DONE) begin
      nxt = IDLE;
    end
  end
  // write k reads w[k%N][k/N], i.e. the transpose of the row-major buffer
  always_comb begin
    rd = IW'((int'(cnt) % N) * N + int'(cnt) / N);
    in_ready = state == COLLECT;
    mem_we = state == WRITE;
    busy = state == COLLECT || state == WRITE;
    done = state == DONE;
    mem_addr = mem_we ? BASE_ADDR + ADDR_WIDTH'(cnt) : '0;
    mem_wdata = mem_we ? wbuf[rd] : '0;
  end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized stream loads on N=2 and N=3 loaders checked against a matrix-level reference.
module tb_weight_loader;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [15:0] in_data = 0;
  logic rdy2, we2, busy2, done2, rdy3, we3, busy3, done3;
  logic [12:0] addr2, addr3;
  logic [15:0] wd2, wd3;
  logic o_rdy, o_we, o_busy, o_done;
  logic [12:0] o_addr;
  logic [15:0] o_wd;
  int cur = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  weight_loader #(.N(2), .BASE_ADDR(13'h000F)) u2 (
    .clk(clk), .reset(reset), .start(start && cur == 0), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2), .done(done2));
  weight_loader #(.N(3), .BASE_ADDR(13'h1FFE)) u3 (
    .clk(clk), .reset(reset), .start(start && cur == 1), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wd3), .busy(busy3), .done(done3));
  always_comb begin
    o_rdy = cur == 1 ? rdy3 : rdy2;
    o_we = cur == 1 ? we3 : we2;
    o_busy = cur == 1 ? busy3 : busy2;
    o_done = cur == 1 ? done3 : done2;
    o_addr = cur == 1 ? addr3 : addr2;
    o_wd = cur == 1 ? wd3 : wd2;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one matrix load; caller is at a negedge, returns at the negedge of the IDLE cycle after done
  task automatic run_load(input int sel, input bit gaps, input bit spurious, input int first);
    int n, nn, acc, ta, k;
    logic [12:0] base;
    logic [15:0] w [9];
    logic [15:0] col [$];
    bit fin;
    bit er, ew, ed;
    cur = sel;
    n = sel == 1 ? 3 : 2;
    nn = n * n;
    base = sel == 1 ? 13'h1FFE : 13'h000F;
    for (int i = 0; i < nn; i++) w[i] = first >= 0 ? 16'(first + i) : 16'($urandom);
    col = {};
    for (int c = 0; c < n; c++)
      for (int r = 0; r < n; r++) col.push_back(w[r * n + c]);
    acc = 0;
    ta = -1;
    fin = 0;
    start = 1;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      er = acc < nn;
      ew = ta >= 0 && cyc > ta && cyc <= ta + nn;
      ed = ta >= 0 && cyc == ta + nn + 1;
      k = cyc - ta - 1;
      check("in_ready", o_rdy, er);
      check("mem_we", o_we, ew);
      check("busy", o_busy, er || ew);
      check("done", o_done, ed);
      check("mem_addr", o_addr, ew ? 32'((base + 13'(k)) & 13'h1FFF) : 0);
      check("mem_wdata", o_wd, ew ? 32'(col[k]) : 0);
      if (ta >= 0 && cyc == ta + nn + 2) begin
        fin = 1;
        start = 0;
        in_valid = 0;
      end else begin
        start = spurious && $urandom_range(0, 2) == 0;
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data = 16'($urandom);
        if (er && in_valid) begin
          in_data = w[acc];
          acc++;
          if (acc == nn) ta = cyc;
        end
      end
    end
    check("load_finished", fin, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready2", rdy2, 0);
    check("rst_we2", we2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_addr2", addr2, 0);
    check("rst_wdata2", wd2, 0);
    check("rst_busy3", busy3, 0);
    check("rst_addr3", addr3, 0);
    reset = 0;
    @(negedge clk);
    run_load(0, 0, 0, 3);
    run_load(0, 1, 0, 3);
    run_load(0, 1, 1, 3);
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    in_data = 3;
    @(negedge clk);
    in_data = 4;
    @(negedge clk);
    in_valid = 0;
    #2 reset = 1;
    #1;
    check("midrst_ready", rdy2, 0);
    check("midrst_busy", busy2, 0);
    check("midrst_we", we2, 0);
    check("midrst_done", done2, 0);
    @(negedge clk);
    reset = 0;
    run_load(0, 0, 0, 3);
    run_load(0, 0, 0, 7);
    run_load(1, 0, 0, 1);
    run_load(1, 1, 1, -1);
    for (int i = 0; i < 6; i++) run_load(i % 2, 1, 1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Row-major weight-matrix loader that fills the weight store from a valid/ready input stream. Collects one N×N matrix, transposes it, and writes it column-major at `BASE_ADDR` through a single-word write port, one word per cycle. Sits between the host-side weight stream and the weight memory's write side, so the read side can fetch one column of N weights at `addr`, `addr+1`, and so on.

## Interface
- `N`, default 2: systolic array dimension; the matrix has N×N words, N ≥ 2.
- `DATA_WIDTH`, default 16: weight word width.
- `ADDR_WIDTH`, default 13: weight memory address width.
- `BASE_ADDR`, default 13'h000F: first memory address written.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request to load one matrix; honoured only in IDLE.
- `in_valid`  in  1: `in_data` carries a weight.
- `in_ready`  out  1: loader accepts a beat; a beat transfers when `in_valid && in_ready` at a rising edge.
- `in_data`  in  DATA_WIDTH: weight `w[r][c]`, presented row-major (beat index i = r*N + c).
- `mem_we`  out  1: write strobe to the weight memory.
- `mem_addr`  out  ADDR_WIDTH: write address.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `busy`  out  1: high in COLLECT and WRITE.
- `done`  out  1: one-cycle pulse after the last memory write.

## Operation
- Internal N×N buffer of DATA_WIDTH registers, plus a beat/write counter of width clog2(N*N)+1.
- FSM has four states: IDLE, COLLECT, WRITE, DONE.
- **IDLE**
  - `in_ready`=0 and `mem_we`=0.
  - `start`=1 → COLLECT with the counter cleared.
  - `in_valid` is ignored in IDLE.
- **COLLECT**
  - `in_ready`=1.
  - Each accepted beat stores `in_data` into `buf[i]` and increments the counter.
  - Cycles with `in_valid`=0 leave all state unchanged.
  - When the beat with i = N*N−1 is accepted → WRITE with the counter cleared.
- **WRITE**
  - `in_ready`=0 and `mem_we`=1 for exactly N*N consecutive cycles, k = 0..N*N−1.
  - `mem_addr` = BASE_ADDR + k, truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
  - `mem_wdata` = `w[r][c]` with c = k / N and r = k % N, which is the transposed, column-major layout.
  - After k = N*N−1 → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; it is neither queued nor does it restart the load.
- Outputs decode from registered state, counter and buffer only; there is no combinational path from any input to any output.

## Timing
- **Reset:**
  - While `reset`=1: state=IDLE, counter=0, buffer cleared to 0.
  - Outputs during reset: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0.
  - Outside WRITE, `mem_addr` and `mem_wdata` are driven to 0.
- **Reset mid-operation:** state returns to IDLE immediately, no further writes occur, and a partially collected matrix is discarded. Words already written stay in memory.
- **Latency with `in_valid` held high:**
  - `start` sampled at edge 0 → `in_ready`=1 in cycle 1.
  - Beats are accepted at edges 1..N*N.
  - Writes occur in cycles N*N+1 .. 2*N*N.
  - `done`=1 in cycle 2*N*N+1.
  - For N=2: write cycles 5–8, `done` in cycle 9.
- **Throughput:** one matrix per 2*N*N+2 cycles minimum, including the IDLE cycle needed to sample `start`.
- Gaps in `in_valid` stretch COLLECT cycle-for-cycle; WRITE duration is fixed.
- `start` asserted in the DONE cycle is ignored. `start` in the following IDLE cycle is honoured.

## Test plan
- **Basic N=2:** `start`, then beats 3,4,5,6 back-to-back → writes (F,3), (10,5), (11,4), (12,6) in cycles 5–8; `done` in cycle 9; `busy` high in cycles 1–8.
- **Input gaps:** same data with `in_valid` toggling 1,0,0,1,1,0,1 → identical write sequence; WRITE starts the cycle after the 4th accepted beat; no beat is lost or duplicated.
- **Ignored start:** pulse `start` during COLLECT and during WRITE → exactly 4 writes and one `done`; FSM returns to IDLE; `in_ready` stays 0 afterwards.
- **Async reset mid-op:**
  - Assert `reset` after 2 accepted beats → `in_ready`=0, `busy`=0 immediately with no writes.
  - A fresh load of 3,4,5,6 then produces the correct 4 writes.
- **N=3, BASE_ADDR=13'h1FFE:** stream beats 1..9 → write data 1,4,7,2,5,8,3,6,9 at addresses 1FFE, 1FFF, 0000, 0001, …, 0006 (address wrap).
- **Back-to-back loads:** `start` in the cycle after `done` with a new matrix 7,8,9,10 → writes (F,7), (10,9), (11,8), (12,10).
